// File: rtl/alu_exec_pkg.sv
// Shared definitions for the alu_exec execution-stage ALU.
// Contents: default operand width, aluOp encodings, control FSM state encoding.
package alu_exec_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StFinish = 2'd2
    } state_e;

endpackage

// File: rtl/alu_exec_muldiv_seq.sv
// Sequential signed multiply / divide engine for alu_exec.
// Works on operand magnitudes, one iteration per clock for WIDTH clocks,
// and applies the result signs combinationally on the outputs.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   go_i          load operands and start iterating (single-cycle pulse)
//   is_div_i      1 = restoring divide, 0 = shift-add multiply
//   op_a_i/op_b_i multiplicand,multiplier / dividend,divisor (signed)
//   fin_o         high during the cycle whose edge performs the last iteration
//   prod_o        signed 2*WIDTH product
//   quot_o/rem_o  quotient (truncated toward zero) / remainder (dividend's sign)
module alu_muldiv_seq
    import alu_exec_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go_i,
    input  logic                 is_div_i,
    input  logic [WIDTH-1:0]     op_a_i,
    input  logic [WIDTH-1:0]     op_b_i,
    output logic                 fin_o,
    output logic [2*WIDTH-1:0]   prod_o,
    output logic [WIDTH-1:0]     quot_o,
    output logic [WIDTH-1:0]     rem_o
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic             run_q, div_q, neg_q, rem_neg_q;
    logic [CntW-1:0]  cnt_q;
    // hi_q: partial product high word / partial remainder
    // lo_q: multiplier being consumed / dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] hi_q, lo_q, m_q;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     add_sum, shifted, diff;
    logic               ge;
    logic [2*WIDTH-1:0] prod_mag;

    // Magnitude of the most-negative value is 2^(WIDTH-1), which still fits unsigned.
    assign a_mag = op_a_i[WIDTH-1] ? ('0 - op_a_i) : op_a_i;
    assign b_mag = op_b_i[WIDTH-1] ? ('0 - op_b_i) : op_b_i;

    always_comb begin
        add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, m_q};
        ge      = (shifted >= {1'b0, m_q});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q     <= 1'b0;
            div_q     <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            m_q       <= '0;
        end else if (go_i) begin
            run_q     <= 1'b1;
            cnt_q     <= '0;
            div_q     <= is_div_i;
            hi_q      <= '0;
            lo_q      <= is_div_i ? a_mag : b_mag;
            m_q       <= is_div_i ? b_mag : a_mag;
            neg_q     <= op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1];
            rem_neg_q <= op_a_i[WIDTH-1];
        end else if (run_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (fin_o) begin
                run_q <= 1'b0;
            end
            if (div_q) begin
                hi_q <= ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                lo_q <= {lo_q[WIDTH-2:0], ge};
            end else begin
                {hi_q, lo_q} <= {add_sum, lo_q[WIDTH-1:1]};
            end
        end
    end

    assign fin_o    = run_q && (cnt_q == CntW'(WIDTH - 1));
    assign prod_mag = {hi_q, lo_q};
    assign prod_o   = neg_q ? ('0 - prod_mag) : prod_mag;
    assign quot_o   = neg_q ? ('0 - lo_q) : lo_q;
    assign rem_o    = rem_neg_q ? ('0 - hi_q) : hi_q;

endmodule

// File: rtl/alu_exec.sv
// Execution-stage ALU with start/busy/done handshake.
// ADD/SUB/AND/OR/SLL/SRL finish in one cycle; signed MUL/DIV iterate in
// alu_muldiv_seq for WIDTH cycles (latency WIDTH+1). DIV by zero is single-cycle.
// Optional build macro ALU_FAST_MUL_EN: MUL becomes a single-cycle combinational op.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, aluOp        request and opcode; start is only sampled while idle
//   operandA/operandB   operands (B low bits are the shift amount)
//   busy, done          iteration in progress / one-cycle result strobe
//   result, resultHi    low word or quotient / high word or remainder
//   zero, overflow, divByZero  status flags, updated with done
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       aluOp,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] resultHi,
    output logic             zero,
    output logic             overflow,
    output logic             divByZero
);

    localparam int unsigned ShW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q;
    logic             busy_q, done_q, zero_q, ovf_q, dbz_q;
    logic             div_q, div_ovf_q;
    logic [WIDTH-1:0] res_q, hi_q;

    // Single-cycle datapath, evaluated on the live inputs at the accept edge.
    logic [WIDTH-1:0] sum, dif, sc_res, sc_hi;
    logic [ShW-1:0]   shamt;
    logic             sc_ovf, sc_dbz, sc_multi;

    assign sum   = operandA + operandB;
    assign dif   = operandA - operandB;
    assign shamt = operandB[ShW-1:0];

`ifdef ALU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = $signed({{WIDTH{operandA[WIDTH-1]}}, operandA})
                     * $signed({{WIDTH{operandB[WIDTH-1]}}, operandB});
`endif

    always_comb begin
        sc_res   = '0;
        sc_hi    = '0;
        sc_ovf   = 1'b0;
        sc_dbz   = 1'b0;
        sc_multi = 1'b0;
        case (aluOp)
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (operandA[WIDTH-1] == operandB[WIDTH-1]) &&
                         (sum[WIDTH-1] != operandA[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = dif;
                sc_ovf = (operandA[WIDTH-1] != operandB[WIDTH-1]) &&
                         (dif[WIDTH-1] != operandA[WIDTH-1]);
            end
            OP_AND: sc_res = operandA & operandB;
            OP_OR:  sc_res = operandA | operandB;
            OP_SLL: sc_res = operandA << shamt;
            OP_SRL: sc_res = operandA >> shamt;
            OP_MUL: begin
`ifdef ALU_FAST_MUL_EN
                sc_res = fast_prod[WIDTH-1:0];
                sc_hi  = fast_prod[2*WIDTH-1:WIDTH];
                sc_ovf = fast_prod[2*WIDTH-1:WIDTH] != {WIDTH{fast_prod[WIDTH-1]}};
`else
                sc_multi = 1'b1;
`endif
            end
            OP_DIV: begin
                if (operandB == '0) begin
                    sc_res = '1;
                    sc_hi  = operandA;
                    sc_dbz = 1'b1;
                end else begin
                    sc_multi = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Sequential MUL/DIV engine.
    logic               md_go, md_fin;
    logic [2*WIDTH-1:0] md_prod;
    logic [WIDTH-1:0]   md_quot, md_rem;

    assign md_go = (state_q == StIdle) && start && sc_multi;

    alu_muldiv_seq #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .go_i     (md_go),
        .is_div_i (aluOp == OP_DIV),
        .op_a_i   (operandA),
        .op_b_i   (operandB),
        .fin_o    (md_fin),
        .prod_o   (md_prod),
        .quot_o   (md_quot),
        .rem_o    (md_rem)
    );

    logic [WIDTH-1:0] fin_res, fin_hi;
    logic             fin_ovf;

    always_comb begin
        if (div_q) begin
            fin_res = md_quot;
            fin_hi  = md_rem;
            fin_ovf = div_ovf_q;
        end else begin
            fin_res = md_prod[WIDTH-1:0];
            fin_hi  = md_prod[2*WIDTH-1:WIDTH];
            fin_ovf = md_prod[2*WIDTH-1:WIDTH] != {WIDTH{md_prod[WIDTH-1]}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_q     <= '0;
            hi_q      <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
            div_q     <= 1'b0;
            div_ovf_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (sc_multi) begin
                            state_q   <= StRun;
                            busy_q    <= 1'b1;
                            div_q     <= (aluOp == OP_DIV);
                            // Only overflowing divide: most-negative / -1.
                            div_ovf_q <= (operandA == MinNeg) && (operandB == '1);
                        end else begin
                            done_q <= 1'b1;
                            res_q  <= sc_res;
                            hi_q   <= sc_hi;
                            zero_q <= (sc_res == '0);
                            ovf_q  <= sc_ovf;
                            dbz_q  <= sc_dbz;
                        end
                    end
                end
                StRun: begin
                    if (md_fin) begin
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    res_q   <= fin_res;
                    hi_q    <= fin_hi;
                    zero_q  <= (fin_res == '0);
                    ovf_q   <= fin_ovf;
                    dbz_q   <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = res_q;
    assign resultHi  = hi_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign divByZero = dbz_q;

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;
    import alu_exec_pkg::*;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   aluOp = 3'b000;
    logic [W-1:0] operandA = '0;
    logic [W-1:0] operandB = '0;
    logic         busy, done, zero, overflow, divByZero;
    logic [W-1:0] result, resultHi;

    int n_vec = 0;
    int n_bad = 0;

    alu_exec #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .aluOp     (aluOp),
        .operandA  (operandA),
        .operandB  (operandB),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .resultHi  (resultHi),
        .zero      (zero),
        .overflow  (overflow),
        .divByZero (divByZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Checks the full output set at a done cycle.
    task automatic check_out(input string tag, input logic [W-1:0] res, input logic [W-1:0] hi,
                             input logic ovf, input logic zr, input logic dbz);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_res"}, 32'(result), 32'(res));
        check({tag, "_hi"}, 32'(resultHi), 32'(hi));
        check({tag, "_ovf"}, 32'(overflow), 32'(ovf));
        check({tag, "_zero"}, 32'(zero), 32'(zr));
        check({tag, "_dbz"}, 32'(divByZero), 32'(dbz));
    endtask

    // Issues one op at a negedge; returns at the negedge where done is seen.
    // lat counts negedges after the accept edge (1 = single-cycle), -1 on timeout.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
        @(negedge clk);
        start = 1'b1; aluOp = op; operandA = a; operandB = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    initial begin
        int lat, k, nbusy, seen;

        // Reset
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", 32'(result), 32'd0);
        check("rst_flags", 32'({zero, overflow, divByZero}), 32'd0);
        rst = 1'b0;

        // ADD with signed overflow
        do_op(OP_ADD, 16'h7FFF, 16'h0001, lat);
        check("add_lat", 32'(lat), 32'd1);
        check("add_busy", 32'(busy), 32'd0);
        check_out("add", 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("add_done_pulse", 32'(done), 32'd0);
        check("add_hold", 32'(result), 32'h8000);

        // MUL -3 * 7, with an ignored start while busy, then back-to-back SLL
        @(negedge clk);
        start = 1'b1; aluOp = OP_MUL; operandA = 16'hFFFD; operandB = 16'h0007;
        @(negedge clk);
        start = 1'b0;
        k = 1; nbusy = 0;
        while (!done && k < 40) begin
            if (busy) nbusy++;
            if (k == 5) begin
                start = 1'b1; aluOp = OP_ADD; operandA = 16'h0001; operandB = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        check("mul_lat", 32'(k), 32'd18);
        check("mul_busy_cycles", 32'(nbusy), 32'd17);
        check("mul_busy_end", 32'(busy), 32'd0);
        check_out("mul", 16'hFFEB, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        start = 1'b1; aluOp = OP_SLL; operandA = 16'h0001; operandB = 16'h0013;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd0);
        check_out("b2b_sll", 16'h0008, 16'h0000, 1'b0, 1'b0, 1'b0);

        // DIV -7 / 2
        do_op(OP_DIV, 16'hFFF9, 16'h0002, lat);
        check("div_lat", 32'(lat), 32'd18);
        check_out("div", 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 1'b0);

        // DIV by zero, then ADD 0+0 clears divByZero
        do_op(OP_DIV, 16'h1234, 16'h0000, lat);
        check("dbz_lat", 32'(lat), 32'd1);
        check("dbz_busy", 32'(busy), 32'd0);
        check_out("dbz", 16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b1);
        do_op(OP_ADD, 16'h0000, 16'h0000, lat);
        check_out("add0", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Remaining single-cycle ops
        do_op(OP_SUB, 16'h8000, 16'h0001, lat);
        check_out("sub_ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1'b0);
        do_op(OP_SUB, 16'h0005, 16'h0007, lat);
        check_out("sub", 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0);
        do_op(OP_AND, 16'hF0F0, 16'h3C3C, lat);
        check_out("and", 16'h3030, 16'h0000, 1'b0, 1'b0, 1'b0);
        do_op(OP_OR, 16'hF000, 16'h000F, lat);
        check_out("or", 16'hF00F, 16'h0000, 1'b0, 1'b0, 1'b0);
        do_op(OP_SRL, 16'h8000, 16'h000F, lat);
        check_out("srl15", 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
        do_op(OP_SRL, 16'hF000, 16'hFFF4, lat);
        check_out("srl_upper", 16'h0F00, 16'h0000, 1'b0, 1'b0, 1'b0);

        // MUL overflow cases
        do_op(OP_MUL, 16'h0100, 16'h0100, lat);
        check_out("mul_ovf", 16'h0000, 16'h0001, 1'b1, 1'b1, 1'b0);
        do_op(OP_MUL, 16'h8000, 16'hFFFF, lat);
        check_out("mul_minneg", 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0);

        // DIV boundary and sign cases
        do_op(OP_DIV, 16'h8000, 16'hFFFF, lat);
        check_out("div_minneg", 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0);
        do_op(OP_DIV, 16'h0007, 16'hFFFE, lat);
        check_out("div_negb", 16'hFFFD, 16'h0001, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a MUL
        @(negedge clk);
        start = 1'b1; aluOp = OP_MUL; operandA = 16'h0003; operandB = 16'h0005;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_res", 32'({result, resultHi}), 32'd0);
        check("mid_flags", 32'({done, zero, overflow, divByZero}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        check("mid_no_done", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
Name: alu_exec

Overview:
- Execution-stage ALU that consumes the 3-bit aluOp produced by alu_control.
- Operates on two WIDTH-bit operands.
- Logic and shift ops complete in one cycle. Signed multiply and divide run as multi-cycle sequential operations.
- A start/busy/done handshake lets the control FSM stall the pipeline while MUL/DIV is in progress.

Parameters:
WIDTH, 16, operand and result width in bits; shift amount is operandB[log2(WIDTH)-1:0]

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled only while busy=0
aluOp  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLL, 101 SRL, 110 MUL, 111 DIV
operandA  input  WIDTH  first operand / dividend
operandB  input  WIDTH  second operand / divisor / shift amount
busy  output  1  high while MUL/DIV iterates
done  output  1  one-cycle pulse when result/flags update
result  output  WIDTH  low word / quotient
resultHi  output  WIDTH  MUL high word / DIV remainder; 0 for other ops
zero  output  1  result == 0
overflow  output  1  signed overflow, per op rules below
divByZero  output  1  DIV with operandB == 0

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, result, resultHi, zero, overflow, divByZero all 0. Reset mid-MUL/DIV aborts the operation; no done pulse follows.
- States: IDLE, RUN, FINISH.
- Accept: start=1 at edge E while in IDLE latches aluOp, operandA and operandB. start while busy=1 is ignored, not queued.
- Single-cycle ops (ADD..SRL): result and flags are registered at edge E. done=1 for the cycle after E. busy stays 0.
- MUL/DIV timing:
  - IDLE→RUN at E; busy=1 after E.
  - One iteration per edge at E+1..E+WIDTH.
  - RUN→FINISH after the WIDTH-th iteration.
  - At edge E+WIDTH+1, outputs are registered, done=1 and busy=0.
  - Total latency WIDTH+1 cycles. FINISH→IDLE.
- Back-to-back: start during the done cycle is accepted (busy=0 then).
- ADD/SUB: two's complement. overflow = signed overflow. resultHi=0.
- AND/OR/SLL/SRL: overflow=0. Shifts are logical, using amount operandB[log2(WIDTH)-1:0]; upper bits are ignored.
- MUL:
  - Signed 2W-bit product; low word to result, high word to resultHi.
  - overflow=1 iff the product does not fit a signed WIDTH value.
  - Implemented as shift-add on magnitudes, with sign fixed at FINISH.
- DIV:
  - Signed restoring divide; quotient truncates toward zero; remainder takes the dividend's sign.
  - operandB=0: no iteration, 1-cycle latency, result all ones, resultHi=operandA, divByZero=1, overflow=0.
  - Most-negative / -1: result=most-negative, resultHi=0, overflow=1.
- zero always reflects result only. divByZero clears on the next done.
- All outputs hold their last values between done pulses.

Optional Feature:
- Macro: ALU_FAST_MUL_EN.
- Defined: MUL is computed combinationally and behaves as a single-cycle op (done the cycle after E, busy never asserts). DIV is unchanged.
- Undefined: MUL is sequential as above. The feature must not change results or flags, only latency.

Decomposition:
- Package alu_exec_pkg holds:
  - aluOp encodings as named constants (OP_ADD..OP_DIV);
  - the state encoding (IDLE, RUN, FINISH);
  - the default WIDTH.
- One sub-module, alu_muldiv_seq, owns:
  - the iteration counter and shift registers;
  - sign handling for MUL/DIV;
  - its interface: go, isDiv, operands, fin, product/quotient/remainder.
- The top level keeps the FSM, single-cycle datapath, flags and handshake.

Test Plan:
- ADD: A=0x7FFF, B=0x0001, start → one cycle later done=1, result=0x8000, overflow=1, zero=0, busy never high.
- MUL: A=0xFFFD (-3), B=0x0007, start → busy high 17 cycles, then done=1, result=0xFFEB, resultHi=0xFFFF, overflow=0. A start pulsed at cycle 5 is ignored.
- DIV: A=0xFFF9 (-7), B=0x0002 → after 17 cycles, result=0xFFFD, resultHi=0xFFFF.
- DIV by zero: A=0x1234, B=0 → done after 1 cycle, result=0xFFFF, resultHi=0x1234, divByZero=1. Next ADD 0+0 clears divByZero and gives zero=1.
- Reset mid-op: start MUL, assert rst at cycle 5 → busy=0 and all outputs 0 immediately; no done pulse within the next 20 cycles.
- Back-to-back shift: SLL A=0x0001, B=0x0013 (amount 3) → result=0x0008. Start asserted in the MUL done cycle is accepted and completes next cycle.
